// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU control codes,
// immediate formats, result-source selects and the decoded control bundle.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Control bundle produced by the main decoder
    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        imm_src_e    imm_src;
        alu_op_e     alu_op;
    } ctrl_t;

    // Sign-extend the immediate field selected by the instruction format
    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                   input imm_src_e    src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port. x0 is hardwired to zero; a read of the register being written in
// the same cycle returns the incoming write data.
module register_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] a1,
    input  logic [REG_AW-1:0] a2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] a3,
    input  logic [XLEN-1:0]   wd
);

    // x0 has no storage; only x1..x31 are held
    logic [XLEN-1:0] regs [1:NREG-1];

    logic write_en;
    assign write_en = we && (a3 != '0);

    // Write port: clear all registers on reset, otherwise write on enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[a3] <= wd;
        end
    end

    // Read ports: x0 reads zero, same-cycle write is forwarded
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != '0) begin
            rd1 = (write_en && (a3 == a1)) ? wd : regs[a1];
        end
        if (a2 != '0) begin
            rd2 = (write_en && (a3 == a2)) ? wd : regs[a2];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decode, immediate extension, register-file
// read, and the ID/EX pipeline register feeding Execute.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;

    assign opcode   = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7_5 = InstrD[30];

    ctrl_t           ctrl;
    alu_ctrl_e       alu_control;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    register_file u_register_file (
        .clk (clk),
        .rst (rst),
        .a1  (rs1),
        .a2  (rs2),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (RegWriteW),
        .a3  (RDW),
        .wd  (ResultW)
    );

    // Main decoder: opcode to control bundle; unknown opcodes become a NOP
    always_comb begin
        ctrl = '{reg_write: 1'b0, result_src: RES_ALU, mem_write: 1'b0,
                 jump: 1'b0, branch: 1'b0, alu_src: 1'b0,
                 imm_src: IMM_I, alu_op: ALUOP_ADD};
        case (opcode)
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_src    = IMM_I;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                ctrl.branch  = 1'b1;
                ctrl.imm_src = IMM_B;
                ctrl.alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    // ALU decoder: subtract only for R-type with funct7[5]; addi never subtracts
    always_comb begin
        alu_control = ALU_ADD;
        case (ctrl.alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    assign imm_ext = imm_extend(InstrD, ctrl.imm_src);

    // ID/EX register: flush clears control and RdE, data still loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RD1E     <= rd1;
            RD2E     <= rd2;
            ImmExtE  <= imm_ext;
            Rs1E     <= rs1;
            Rs2E     <= rs2;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            if (FlushE) begin
                RegWriteE   <= 1'b0;
                ResultSrcE  <= 2'b00;
                MemWriteE   <= 1'b0;
                JumpE       <= 1'b0;
                BranchE     <= 1'b0;
                ALUControlE <= 3'b000;
                ALUSrcE     <= 1'b0;
                RdE         <= '0;
            end else begin
                RegWriteE   <= ctrl.reg_write;
                ResultSrcE  <= ctrl.result_src;
                MemWriteE   <= ctrl.mem_write;
                JumpE       <= ctrl.jump;
                BranchE     <= ctrl.branch;
                ALUControlE <= alu_control;
                ALUSrcE     <= ctrl.alu_src;
                RdE         <= rd;
            end
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: hand-computed vectors, immediate assertions,
// and an expected queue for the PC pass-through.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic        JumpE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmExtE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic write_w(input logic en, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = en;
        RDW       = rd;
        ResultW   = data;
    endtask

    task automatic check_ctrl_zero(input string tag);
        check({tag, "_regwrite"}, {31'd0, RegWriteE}, 32'd0);
        check({tag, "_memwrite"}, {31'd0, MemWriteE}, 32'd0);
        check({tag, "_jump"},     {31'd0, JumpE},     32'd0);
        check({tag, "_branch"},   {31'd0, BranchE},   32'd0);
        check({tag, "_alusrc"},   {31'd0, ALUSrcE},   32'd0);
        check({tag, "_ressrc"},   {30'd0, ResultSrcE}, 32'd0);
        check({tag, "_aluctl"},   {29'd0, ALUControlE}, 32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        FlushE = 1'b0;
        drive(32'h0, 32'h0);
        write_w(1'b0, 5'd0, 32'h0);
        #12;
        check_ctrl_zero("por");
        check("por_rd1", RD1E, 32'h0);
        check("por_pce", PCE, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write x5 = 0xAA, then addi x6,x5,5
        drive(32'h0000_0000, 32'h0000_0010);
        write_w(1'b1, 5'd5, 32'h0000_00AA);
        step();
        write_w(1'b0, 5'd0, 32'h0);
        drive(32'h0052_8313, 32'h0000_0014);
        step();
        check("addi_rd1", RD1E, 32'h0000_00AA);
        check("addi_imm", ImmExtE, 32'h0000_0005);
        check("addi_alusrc", {31'd0, ALUSrcE}, 32'd1);
        check("addi_regwrite", {31'd0, RegWriteE}, 32'd1);
        check("addi_rd", {27'd0, RdE}, 32'd6);
        check("addi_rs1", {27'd0, Rs1E}, 32'd5);
        check("addi_aluctl", {29'd0, ALUControlE}, 32'd0);
        check("addi_pce", PCE, 32'h0000_0014);
        check("addi_pc4e", PCPlus4E, 32'h0000_0018);

        // Same-cycle write/read of x7 forwards ResultW
        drive(32'h0003_8413, 32'h0000_0018);
        write_w(1'b1, 5'd7, 32'h0000_1234);
        step();
        check("bypass_rd1", RD1E, 32'h0000_1234);
        // Write to x0 is dropped and not forwarded
        drive(32'h0000_0493, 32'h0000_001C);
        write_w(1'b1, 5'd0, 32'hDEAD_BEEF);
        step();
        check("x0_bypass_rd1", RD1E, 32'h0);
        write_w(1'b0, 5'd0, 32'h0);
        step();
        check("x0_rd1", RD1E, 32'h0);
        // x7 holds the written value
        drive(32'h0003_8413, 32'h0000_0020);
        step();
        check("x7_hold_rd1", RD1E, 32'h0000_1234);

        // Mid-run asynchronous reset
        drive(32'h0052_8313, 32'h0000_0024);
        step();
        check("pre_rst_rd1", RD1E, 32'h0000_00AA);
        #2;
        rst = 1'b1;
        #1;
        check_ctrl_zero("async_rst");
        check("async_rst_rd1", RD1E, 32'h0);
        check("async_rst_imm", ImmExtE, 32'h0);
        check("async_rst_rd", {27'd0, RdE}, 32'd0);
        check("async_rst_pce", PCE, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("x5_cleared_rd1", RD1E, 32'h0);
        check("x5_cleared_imm", ImmExtE, 32'h0000_0005);

        // beq x0,x0,-4
        drive(32'hFE00_0EE3, 32'h0000_0040);
        step();
        check("beq_branch", {31'd0, BranchE}, 32'd1);
        check("beq_aluctl", {29'd0, ALUControlE}, 32'b001);
        check("beq_imm", ImmExtE, 32'hFFFF_FFFC);
        check("beq_regwrite", {31'd0, RegWriteE}, 32'd0);

        // jal x1,8
        drive(32'h0080_00EF, 32'h0000_0044);
        step();
        check("jal_jump", {31'd0, JumpE}, 32'd1);
        check("jal_ressrc", {30'd0, ResultSrcE}, 32'b10);
        check("jal_imm", ImmExtE, 32'h0000_0008);
        check("jal_regwrite", {31'd0, RegWriteE}, 32'd1);
        check("jal_rd", {27'd0, RdE}, 32'd1);

        // sw x2,0(x1) under flush; a writeback to x2 lands in the same cycle
        drive(32'h0020_A023, 32'h0000_0048);
        FlushE = 1'b1;
        write_w(1'b1, 5'd2, 32'h0000_0055);
        step();
        FlushE = 1'b0;
        write_w(1'b0, 5'd0, 32'h0);
        check("sw_flush_memwrite", {31'd0, MemWriteE}, 32'd0);
        check("sw_flush_regwrite", {31'd0, RegWriteE}, 32'd0);
        check("sw_flush_alusrc", {31'd0, ALUSrcE}, 32'd0);
        check("sw_flush_rd", {27'd0, RdE}, 32'd0);
        step();
        check("sw_memwrite", {31'd0, MemWriteE}, 32'd1);
        check("sw_imm", ImmExtE, 32'h0);
        check("sw_alusrc", {31'd0, ALUSrcE}, 32'd1);
        check("sw_rs2", {27'd0, Rs2E}, 32'd2);
        check("sw_rd2_flush_write", RD2E, 32'h0000_0055);

        // sub x3,x1,x2
        drive(32'h4020_81B3, 32'h0000_0050);
        step();
        check("sub_aluctl", {29'd0, ALUControlE}, 32'b001);
        check("sub_alusrc", {31'd0, ALUSrcE}, 32'd0);
        // slt x3,x1,x2
        drive(32'h0020_A1B3, 32'h0000_0054);
        step();
        check("slt_aluctl", {29'd0, ALUControlE}, 32'b101);
        // or / and
        drive(32'h0020_E1B3, 32'h0000_0058);
        step();
        check("or_aluctl", {29'd0, ALUControlE}, 32'b011);
        drive(32'h0020_F1B3, 32'h0000_005C);
        step();
        check("and_aluctl", {29'd0, ALUControlE}, 32'b010);
        // addi x3,x1,-1: imm bit 30 set must still add
        drive(32'hFFF0_8193, 32'h0000_0060);
        step();
        check("addi_neg_aluctl", {29'd0, ALUControlE}, 32'b000);
        check("addi_neg_imm", ImmExtE, 32'hFFFF_FFFF);
        // lw x3,0(x1)
        drive(32'h0000_A183, 32'h0000_0064);
        step();
        check("lw_ressrc", {30'd0, ResultSrcE}, 32'b01);
        check("lw_regwrite", {31'd0, RegWriteE}, 32'd1);
        check("lw_alusrc", {31'd0, ALUSrcE}, 32'd1);

        // Illegal opcode; PCs tracked through the expected queue
        exp_q.push_back(32'h0000_0100);
        drive(32'hFFFF_FFFF, 32'h0000_0100);
        step();
        check_ctrl_zero("illegal");
        check("illegal_pce", PCE, exp_q.pop_front());
        check("illegal_pc4e", PCPlus4E, 32'h0000_0104);
        check("illegal_rd", {27'd0, RdE}, 32'd31);
        exp_q.push_back(32'h0000_0200);
        drive(32'hFFFF_FFFF, 32'h0000_0200);
        step();
        check("illegal2_pce", PCE, exp_q.pop_front());
        check("illegal2_pc4e", PCPlus4E, 32'h0000_0204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
